// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side and SRAM-pad signals of the MEM-stage SRAM controller.
// The controller takes the slave modport; the pipeline/pad side takes master.
interface mem_sram_ctrl_if #(
    parameter int SRAM_AW = 18
) ();
    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        ALU_result;
    logic [31:0]        ST_val;
    logic [31:0]        Mem_read_value;
    logic               ready;
    logic               freeze;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        SRAM_DQ_out;
    logic               SRAM_DQ_oe;
    logic [15:0]        SRAM_DQ_in;
    logic               SRAM_WE_N;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
        input  Mem_read_value, ready, freeze, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
        output Mem_read_value, ready, freeze, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two halfword
// phases on a 16-bit asynchronous SRAM, stalling the pipeline until done.
module mem_sram_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic             clk,
    input  logic             rst,
    mem_sram_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic               is_write_r;
    logic [SRAM_AW-2:0] hw_addr_r;
    logic [15:0]        st_hi_r;
    logic [31:0]        rd_val_r;
    logic [SRAM_AW-1:0] addr_r;
    logic [15:0]        dq_out_r;
    logic               dq_oe_r;
    logic               we_n_r;

    logic               req_s;
    logic               phase_end_s;
    logic               ready_s;

    // Word index within the SRAM window; bits above the window alias silently.
    function automatic logic [SRAM_AW-2:0] hw_index(input logic [31:0] byte_addr);
        logic [31:0] off;
        off = byte_addr - ADDR_BASE;
        return off[SRAM_AW:2];
    endfunction

    assign req_s       = bus.MEM_R_EN | bus.MEM_W_EN;
    assign phase_end_s = (cnt_r == 4'(WAIT_CYCLES));
    assign ready_s     = (state_r == DONE) | ((state_r == IDLE) & ~req_s);

    assign bus.ready          = ready_s;
    assign bus.freeze         = req_s & ~ready_s;
    assign bus.Mem_read_value = rd_val_r;
    assign bus.SRAM_ADDR      = addr_r;
    assign bus.SRAM_DQ_out    = dq_out_r;
    assign bus.SRAM_DQ_oe     = dq_oe_r;
    assign bus.SRAM_WE_N      = we_n_r;

    // Access sequencer; pad controls are set one edge ahead so they are stable for the whole phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            is_write_r <= 1'b0;
            hw_addr_r  <= '0;
            st_hi_r    <= 16'd0;
            rd_val_r   <= 32'd0;
            addr_r     <= '0;
            dq_out_r   <= 16'd0;
            dq_oe_r    <= 1'b0;
            we_n_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        // A simultaneous read and write request is served as a read.
                        state_r    <= LOW;
                        cnt_r      <= 4'd0;
                        is_write_r <= ~bus.MEM_R_EN;
                        hw_addr_r  <= hw_index(bus.ALU_result);
                        st_hi_r    <= bus.ST_val[31:16];
                        addr_r     <= {hw_index(bus.ALU_result), 1'b0};
                        dq_out_r   <= bus.ST_val[15:0];
                        dq_oe_r    <= ~bus.MEM_R_EN;
                        we_n_r     <= bus.MEM_R_EN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOW: begin
                    if (phase_end_s) begin
                        state_r  <= HIGH;
                        cnt_r    <= 4'd0;
                        addr_r   <= {hw_addr_r, 1'b1};
                        dq_out_r <= st_hi_r;
                        if (!is_write_r) begin
                            rd_val_r[15:0] <= bus.SRAM_DQ_in;
                        end else begin
                            rd_val_r <= rd_val_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                HIGH: begin
                    if (phase_end_s) begin
                        state_r <= DONE;
                        cnt_r   <= 4'd0;
                        dq_oe_r <= 1'b0;
                        we_n_r  <= 1'b1;
                        if (!is_write_r) begin
                            rd_val_r[31:16] <= bus.SRAM_DQ_in;
                        end else begin
                            rd_val_r <= rd_val_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    dq_oe_r <= 1'b0;
                    we_n_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: one instance with one wait state,
// one with none, sharing a small behavioural SRAM.
module tb_mem_sram_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    logic [15:0] mem [0:63];

    logic        s_ready, s_freeze, s_oe, s_we_n;
    logic [17:0] s_addr;
    logic [31:0] s_rd;

    mem_sram_ctrl_if #(.SRAM_AW(18)) bus1 ();
    mem_sram_ctrl_if #(.SRAM_AW(18)) bus0 ();

    mem_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024), .SRAM_AW(18)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(32'd1024), .SRAM_AW(18)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    assign bus1.SRAM_DQ_in = mem[bus1.SRAM_ADDR[5:0]];
    assign bus0.SRAM_DQ_in = mem[bus0.SRAM_ADDR[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every cycle with WE_N low must match the next expected pad write.
    always @(negedge clk) begin
        if (!rst && bus1.SRAM_WE_N === 1'b0) begin
            if (wq.size() == 0) begin
                check_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check_eq("wr_addr", 32'(bus1.SRAM_ADDR), 32'(e.addr));
                check_eq("wr_data", 32'(bus1.SRAM_DQ_out), 32'(e.data));
                check_eq("wr_oe", 32'(bus1.SRAM_DQ_oe), 32'd1);
                mem[bus1.SRAM_ADDR[5:0]] <= bus1.SRAM_DQ_out;
            end
        end
    end

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.MEM_R_EN = r; bus0.MEM_W_EN = w; bus0.ALU_result = a; bus0.ST_val = d;
        end else begin
            bus1.MEM_R_EN = r; bus1.MEM_W_EN = w; bus1.ALU_result = a; bus1.ST_val = d;
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            s_ready = bus0.ready; s_freeze = bus0.freeze; s_oe = bus0.SRAM_DQ_oe;
            s_we_n = bus0.SRAM_WE_N; s_addr = bus0.SRAM_ADDR; s_rd = bus0.Mem_read_value;
        end else begin
            s_ready = bus1.ready; s_freeze = bus1.freeze; s_oe = bus1.SRAM_DQ_oe;
            s_we_n = bus1.SRAM_WE_N; s_addr = bus1.SRAM_ADDR; s_rd = bus1.Mem_read_value;
        end
    endtask

    task automatic go_idle(input int sel);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic access(input int sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, output int done_cyc);
        int          wc;
        int          n;
        logic [17:0] lo;
        logic [17:0] hi;
        wc = (sel == 0) ? 0 : 1;
        lo = 18'(((a - 32'd1024) >> 2) << 1);
        hi = lo | 18'd1;
        @(posedge clk); #1;
        drive(sel, r, w, a, d);
        if (r) begin
            rq.push_back({mem[hi[5:0]], mem[lo[5:0]]});
        end else if (w) begin
            for (int i = 0; i <= wc; i++) wq.push_back('{addr: lo, data: d[15:0]});
            for (int i = 0; i <= wc; i++) wq.push_back('{addr: hi, data: d[31:16]});
        end
        @(negedge clk);
        sample(sel);
        check_eq("req_freeze", 32'(s_freeze), 32'd1);
        check_eq("req_ready", 32'(s_ready), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            sample(sel);
            if (!s_ready) check_eq("phase_addr", 32'(s_addr), (n <= wc + 1) ? 32'(lo) : 32'(hi));
        end while (!s_ready && n < 40);
        check_eq("latency", n, 2 * wc + 3);
        check_eq("done_we_n", 32'(s_we_n), 32'd1);
        check_eq("done_oe", 32'(s_oe), 32'd0);
        check_eq("done_freeze", 32'(s_freeze), 32'd0);
        if (r) begin
            if (rq.size() == 0) check_eq("rd_queue_empty", 32'd1, 32'd0);
            else                check_eq("rd_val", s_rd, rq.pop_front());
        end
        done_cyc = cyc;
    endtask

    initial begin
        int t1;
        int t2;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 64; i++) mem[i] <= 16'(i * 16'h0101);
        mem[4]  <= 16'hBEEF; mem[5]  <= 16'hDEAD;
        mem[2]  <= 16'h1111; mem[3]  <= 16'h2222;
        mem[62] <= 16'h0BAD; mem[63] <= 16'hF00D;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample(1);
        check_eq("rst_rd", s_rd, 32'd0);
        check_eq("rst_addr", 32'(s_addr), 32'd0);
        check_eq("rst_dq_out", 32'(bus1.SRAM_DQ_out), 32'd0);
        check_eq("rst_oe", 32'(s_oe), 32'd0);
        check_eq("rst_we_n", 32'(s_we_n), 32'd1);
        check_eq("rst_ready", 32'(s_ready), 32'd1);
        check_eq("rst_freeze", 32'(s_freeze), 32'd0);
        check_eq("rst_ready0", 32'(bus0.ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        access(1, 1'b1, 1'b0, 32'd1032, 32'd0, t1);                       go_idle(1);
        access(1, 1'b0, 1'b1, 32'd1024, 32'h1234_5678, t1);               go_idle(1);
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0, t1);                       go_idle(1);
        access(1, 1'b1, 1'b1, 32'd1028, 32'hFFFF_0000, t1);               go_idle(1);
        access(1, 1'b1, 1'b0, 32'd1032 + 32'h0008_0000, 32'd0, t1);       go_idle(1);
        access(1, 1'b1, 1'b0, 32'd1020, 32'd0, t1);                       go_idle(1);
        access(1, 1'b0, 1'b1, 32'd1040, 32'hA5A5_5A5A, t1);
        check_eq("rd_held_after_store", bus1.Mem_read_value, 32'hF00D_0BAD);
        go_idle(1);

        // Back-to-back loads with no wait states
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, t1);
        access(0, 1'b1, 1'b0, 32'd1024, 32'd0, t2);
        check_eq("b2b_spacing", t2 - t1, 32'd4);
        go_idle(0);

        // Reset during the high phase of a store aborts it
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 32'd1048, 32'hCAFE_F00D);
        wq.push_back('{addr: 18'd12, data: 16'hF00D});
        wq.push_back('{addr: 18'd12, data: 16'hF00D});
        wq.push_back('{addr: 18'd13, data: 16'hCAFE});
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        sample(1);
        check_eq("abort_we_n", 32'(s_we_n), 32'd1);
        check_eq("abort_oe", 32'(s_oe), 32'd0);
        check_eq("abort_ready", 32'(s_ready), 32'd1);
        check_eq("abort_rd", s_rd, 32'd0);
        check_eq("abort_addr", 32'(s_addr), 32'd0);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("write_queue_drained", wq.size(), 32'd0);
        check_eq("read_queue_drained", rq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
